// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage and the rest of the pipeline: hazard/redirect
// controls, instruction-memory port and the IF/ID register outputs.
interface if_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target, Instruction,
    input  Inst_Address, if_id_pc, if_id_instruction, if_id_valid,
           halted, fault, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, Instruction,
    output Inst_Address, if_id_pc, if_id_instruction, if_id_valid,
           halted, fault, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from an async instruction memory
// into the IF/ID register, handles stalls/redirects and stops at the end of memory.
module if_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_BYTES = 96,
  parameter logic [31:0] NOP       = 32'h00000013
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.slave  bus
);

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES) - 64'd4;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] idPc_q, idPc_d;
  logic [31:0] idInstr_q, idInstr_d;
  logic        idValid_q, idValid_d;
  logic [31:0] fetchCount_q, fetchCount_d;
  logic        inRange;

  assign inRange = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      idPc_q       <= 64'h0;
      idInstr_q    <= NOP;
      idValid_q    <= 1'b0;
      fetchCount_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      idPc_q       <= idPc_d;
      idInstr_q    <= idInstr_d;
      idValid_q    <= idValid_d;
      fetchCount_q <= fetchCount_d;
    end
  end

  // Redirect beats stall; FAULT is sticky until reset.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    idPc_d       = idPc_q;
    idInstr_d    = idInstr_q;
    idValid_d    = idValid_q;
    fetchCount_d = fetchCount_q;
    if (state_q != FAULT) begin
      if (bus.branch_taken) begin
        idPc_d    = 64'h0;
        idInstr_d = NOP;
        idValid_d = 1'b0;
        if (bus.branch_target[1:0] != 2'b00) begin
          state_d = FAULT;
        end else begin
          pc_d    = bus.branch_target;
          state_d = RUN;
        end
      end else if (!bus.stall) begin
        if (state_q == RUN && inRange) begin
          idPc_d       = pc_q;
          idInstr_d    = bus.Instruction;
          idValid_d    = 1'b1;
          pc_d         = pc_q + 64'd4;
          fetchCount_d = (fetchCount_q == 32'hFFFF_FFFF) ? fetchCount_q
                                                         : fetchCount_q + 32'd1;
        end else begin
          idPc_d    = 64'h0;
          idInstr_d = NOP;
          idValid_d = 1'b0;
          if (state_q == RUN) state_d = HALT;
        end
      end
    end
  end

  always_comb begin
    bus.halted = 1'b0;
    bus.fault  = 1'b0;
    if (state_q != RUN)   bus.halted = 1'b1;
    if (state_q == FAULT) bus.fault  = 1'b1;
  end

  assign bus.Inst_Address      = pc_q;
  assign bus.if_id_pc          = idPc_q;
  assign bus.if_id_instruction = idInstr_q;
  assign bus.if_id_valid       = idValid_q;
  assign bus.fetch_count       = fetchCount_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes the expected post-edge state,
// a monitor pops and compares it just after each rising edge.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic reset = 1'b1;

  if_stage_if bus ();

  if_stage #(.RESET_PC(64'h0), .MEM_BYTES(96), .NOP(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        valid;
    logic        halted;
    logic        fault;
    logic [31:0] cnt;
    logic [63:0] addr;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] prog [24];
  int          passCount = 0;
  int          totalCount = 0;

  // Instruction memory: async read, poison word outside the populated range
  always_comb begin
    if (bus.Inst_Address < 64'd96)
      bus.Instruction = prog[bus.Inst_Address[6:2]];
    else
      bus.Instruction = 32'hDEADBEEF;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    totalCount++;
    if (act !== expv)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    else
      passCount++;
  endtask

  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("if_id_pc",          bus.if_id_pc,                  e.pc);
      checkOutput("if_id_instruction", {32'h0, bus.if_id_instruction}, {32'h0, e.ins});
      checkOutput("if_id_valid",       {63'h0, bus.if_id_valid},      {63'h0, e.valid});
      checkOutput("halted",            {63'h0, bus.halted},           {63'h0, e.halted});
      checkOutput("fault",             {63'h0, bus.fault},            {63'h0, e.fault});
      checkOutput("fetch_count",       {32'h0, bus.fetch_count},      {32'h0, e.cnt});
      checkOutput("Inst_Address",      bus.Inst_Address,              e.addr);
    end
  end

  task automatic applyStimulus(
    input logic rst, input logic st, input logic br, input logic [63:0] tgt,
    input logic [63:0] pc, input logic [31:0] ins, input logic valid,
    input logic hlt, input logic flt, input logic [31:0] cnt, input logic [63:0] addr);
    exp_t e;
    @(negedge clk);
    reset             = rst;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    e.pc = pc; e.ins = ins; e.valid = valid; e.halted = hlt;
    e.fault = flt; e.cnt = cnt; e.addr = addr;
    expQ.push_back(e);
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 64'h0;
    prog[0] = 32'h10000513;
    prog[1] = 32'h00500293;
    prog[2] = 32'h00000b13;
    prog[3] = 32'h00128293;
    prog[4] = 32'h001b0b13;
    prog[5] = 32'hfff28293;
    prog[6] = 32'h045b0463;
    prog[7] = 32'h00000b93;
    for (int i = 8; i < 24; i++) prog[i] = 32'h00000093 | (32'(i) << 20);

    //            rst st br tgt      pc      ins           v  h  f  cnt addr
    applyStimulus(1, 0, 0, 64'h0,  64'h0,  NOP,          0, 0, 0, 0, 64'h0);
    applyStimulus(0, 0, 0, 64'h0,  64'h0,  32'h10000513, 1, 0, 0, 1, 64'h4);
    applyStimulus(0, 0, 0, 64'h0,  64'h4,  32'h00500293, 1, 0, 0, 2, 64'h8);
    applyStimulus(0, 1, 0, 64'h0,  64'h4,  32'h00500293, 1, 0, 0, 2, 64'h8);
    applyStimulus(0, 1, 0, 64'h0,  64'h4,  32'h00500293, 1, 0, 0, 2, 64'h8);
    applyStimulus(0, 0, 0, 64'h0,  64'h8,  32'h00000b13, 1, 0, 0, 3, 64'hC);
    applyStimulus(0, 1, 1, 64'h18, 64'h0,  NOP,          0, 0, 0, 3, 64'h18);
    applyStimulus(0, 0, 0, 64'h0,  64'h18, 32'h045b0463, 1, 0, 0, 4, 64'h1C);
    applyStimulus(0, 0, 1, 64'h60, 64'h0,  NOP,          0, 0, 0, 4, 64'h60);
    applyStimulus(0, 0, 0, 64'h0,  64'h0,  NOP,          0, 1, 0, 4, 64'h60);
    applyStimulus(0, 0, 0, 64'h0,  64'h0,  NOP,          0, 1, 0, 4, 64'h60);
    applyStimulus(0, 1, 0, 64'h0,  64'h0,  NOP,          0, 1, 0, 4, 64'h60);
    applyStimulus(0, 0, 1, 64'h1C, 64'h0,  NOP,          0, 0, 0, 4, 64'h1C);
    applyStimulus(0, 0, 0, 64'h0,  64'h1C, 32'h00000b93, 1, 0, 0, 5, 64'h20);
    applyStimulus(0, 0, 1, 64'h1A, 64'h0,  NOP,          0, 1, 1, 5, 64'h20);
    applyStimulus(0, 0, 1, 64'h10, 64'h0,  NOP,          0, 1, 1, 5, 64'h20);
    applyStimulus(0, 0, 0, 64'h0,  64'h0,  NOP,          0, 1, 1, 5, 64'h20);
    applyStimulus(1, 0, 0, 64'h0,  64'h0,  NOP,          0, 0, 0, 0, 64'h0);

    // Free run through the whole populated range, then halt
    for (int i = 0; i < 24; i++)
      applyStimulus(0, 0, 0, 64'h0, 64'(4 * i), prog[i], 1, 0, 0, 32'(i + 1), 64'(4 * i + 4));
    applyStimulus(0, 0, 0, 64'h0, 64'h0, NOP, 0, 1, 0, 24, 64'h60);
    applyStimulus(0, 0, 0, 64'h0, 64'h0, NOP, 0, 1, 0, 24, 64'h60);
    applyStimulus(0, 1, 0, 64'h0, 64'h0, NOP, 0, 1, 0, 24, 64'h60);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      totalCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the program counter, drives the byte address into the instruction memory (asynchronous read, little-endian, 32-bit word returned the same cycle) and registers the returned word together with its PC into the IF/ID pipeline register. It services stalls from the hazard unit and redirects from branch/jump resolution in EX. It stops fetching cleanly when the PC leaves the populated memory range.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- MEM_BYTES, 96, populated instruction-memory size in bytes; valid fetch iff PC + 4 <= MEM_BYTES
- NOP, 32'h00000013, bubble word (addi x0,x0,0)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID
- branch_taken  in  1  EX redirect request
- branch_target  in  64  redirect byte address
- Inst_Address  out  64  combinational copy of PC to instruction memory
- Instruction  in  32  word returned by instruction memory
- if_id_pc  out  64  PC of latched instruction
- if_id_instruction  out  32  latched instruction or NOP
- if_id_valid  out  1  latched slot holds a real instruction
- halted  out  1  state is HALT or FAULT
- fault  out  1  state is FAULT (misaligned redirect)
- fetch_count  out  32  instructions delivered with valid=1, saturating

## Operation
- States: RUN, HALT, FAULT. `halted` = (state != RUN). `fault` = (state == FAULT).
- `in_range` = (PC[1:0] == 0) && (PC <= MEM_BYTES-4). Width: 64-bit unsigned compare, no wrap.
- The following priority is evaluated each edge, highest first:
  1. reset: PC=RESET_PC, state=RUN, if_id_pc=0, if_id_instruction=NOP, if_id_valid=0, fetch_count=0.
  2. state FAULT: everything holds; only reset exits.
  3. branch_taken (overrides stall, any state except FAULT):
     - IF/ID gets bubble (NOP, valid=0, if_id_pc=0).
     - If branch_target[1:0]!=0: state=FAULT, PC holds.
     - Else PC=branch_target, state=RUN.
  4. stall: PC, IF/ID, state, fetch_count hold.
  5. RUN and in_range: if_id_pc=PC, if_id_instruction=Instruction, if_id_valid=1, PC=PC+4, fetch_count+=1, saturating at 32'hFFFFFFFF.
  6. RUN and not in_range: IF/ID bubble, PC holds, state=HALT.
  7. HALT, no redirect: IF/ID bubble, PC holds.
- A redirect into an aligned out-of-range target (e.g. program `j exit` past the end) enters RUN, then HALT on the next non-stalled edge. No X word is ever latched.
- Inst_Address always equals PC, including in HALT and FAULT.

## Timing
- Fetch latency: the word at PC appears on if_id_* one edge after PC is presented.
- Redirect penalty: branch_taken at edge N puts the bubble in IF/ID at N. The target instruction is in IF/ID at N+1.
- Stall is level-sensitive. Each stalled edge freezes the stage for exactly one cycle. There is no internal buffering.
- Reset mid-operation discards the IF/ID contents and any HALT/FAULT state the same edge.
- All outputs are registered except Inst_Address (combinational from the PC register).

## Test plan
- Reset then 3 free edges with program at 0x0: IF/ID shows (0x0,0x10000513), (0x4,0x00500293), (0x8,0x00000b13), valid=1. fetch_count=3, Inst_Address=0xC.
- stall high 2 cycles while PC=0x8: if_id holds (0x4,0x00500293) and PC stays 0x8. After release, (0x8,0x00000b13) latches.
- branch_taken with target 0x18 while stall=1: bubble (NOP, valid=0) at that edge, then (0x18,0x045b0463). fetch_count does not count the bubble.
- Redirect to 0x60 (MEM_BYTES=96): next edge halted=1, valid=0, PC=0x60 held. A later redirect to 0x1C resumes with (0x1C,0x00000b93) and halted=0.
- Redirect to 0x1A: fault=1, halted=1, bubble latched. Further redirects and edges change nothing. reset returns PC=0, fault=0.
- Free-run from 0x0 with no redirects: 24 valid fetches (0x0..0x5C), then HALT. fetch_count=24 and stays.
